tmds_channel_decoder: RTL and testbench
=======================================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS encoder. Decodes one TMDS lane back to pixel data and control bits.
- Input is the unaligned 10-bit parallel word from a per-lane deserializer, in the pixel clock domain.
- Finds the symbol boundary using runs of control tokens, then decodes 10b to 8b data, C0/C1 and DE.
- Three instances (blue/green/red) feed a future DVI input path; the blue lane's C0/C1 carry hsync/vsync.

Parameters:
- CTRL_RUN, 64: consecutive control tokens needed to qualify an alignment.
- SEARCH_TIMEOUT, 2048: cycles without a qualifying run before slipping one bit.
- LOCK_TIMEOUT, 2048: cycles without a qualifying run before lock is declared lost.
- CNT_W, 12: width of the timeout and run counters; must satisfy 2^CNT_W > max(SEARCH_TIMEOUT, LOCK_TIMEOUT).

Ports:
- clk, input, 1: pixel clock (25 MHz for 640x480).
- reset_n, input, 1: asynchronous, active-low reset.
- din, input, 10: raw deserialized word; bit 0 is the first bit received.
- dout, output, 8: decoded pixel byte.
- c0, output, 1: control bit 0.
- c1, output, 1: control bit 1.
- de, output, 1: data enable; 1 for a data symbol.
- locked, output, 1: alignment lock established.
- bit_offset, output, 4: current slip offset, 0..9.

Behaviour:
- Reset (asynchronous, reset_n=0): dout=0, c0=0, c1=0, de=0, locked=0, bit_offset=0, state=SEARCH, all counters 0, din_prev=0.
- Window: din_prev is registered every cycle. w = {din, din_prev} (20 bits). sym = w[bit_offset+9 : bit_offset]. bit_offset=0 selects din_prev.
- Pipeline:
  - Stage 1 registers sym.
  - Stage 2 registers the decode.
  - Outputs appear 2 clocks after the din sample that completes the symbol.
- Control tokens, q[9:0]: 1101010100 -> {c1,c0}=00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11.
  - On a token: de=0, c1/c0 are updated, dout=0.
- Data symbols (any other code):
  - de=1; c1/c0 hold their last values.
  - Let t = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = t[0]; for i=1..7, d[i] = q[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]).
- While locked=0: the stage-2 register forces de=0, dout=0, c0=0, c1=0.
- run_cnt:
  - Increments on each stage-1 token and saturates at CTRL_RUN.
  - Clears on any data symbol.
  - A "qualifying run" is the cycle in which run_cnt reaches CTRL_RUN.
- timer: increments every cycle; cleared on a qualifying run and on every state transition.
- FSM, states SEARCH, VERIFY, LOCKED:
  - SEARCH:
    - Qualifying run -> VERIFY.
    - timer==SEARCH_TIMEOUT-1 -> bit_offset += 1 (9 wraps to 0), run_cnt=0, timer=0, remain in SEARCH.
  - VERIFY:
    - Qualifying run -> LOCKED, locked=1 on the next edge.
    - timer==LOCK_TIMEOUT-1 -> slip exactly as in SEARCH, then -> SEARCH.
  - LOCKED:
    - A qualifying run restarts the timer.
    - timer==LOCK_TIMEOUT-1 -> locked=0, go to SEARCH; bit_offset is unchanged (retry the same offset first).
- Simultaneous events: if a timeout and a qualifying run occur in the same cycle, the qualifying run wins.
- Slip settling: after a slip, stage 1 carries one stale symbol. run_cnt is cleared on the slip cycle, so that stale symbol cannot contribute.
- Reset mid-operation: everything returns to reset values immediately; there is no partial state.

Decomposition:
- Package tmds_pkg holds:
  - The four control-token constants.
  - The state enum {SEARCH, VERIFY, LOCKED}.
  - The token-to-{c1,c0} lookup.
- Sub-module tmds_symbol_decode: combinational q[9:0] -> {is_ctrl, c1, c0, d[7:0]}. It is reused by the alignment logic and the output stage.
- tmds_channel_decoder contains the window mux, counters, FSM and output registers.

Test Plan:
1. Aligned stream: 64 x 1101010100 then data, repeating at 800-cycle lines with 160 blanking -> locked=1 within 2 lines, bit_offset=0, c1/c0=00 during tokens.
2. Stream rotated by 3 bits (serial stream delayed 3 bits) -> bit_offset steps 0,1,2,3 at 2048-cycle intervals, then locked=1 with bit_offset=3; no lock at any other offset.
3. Locked, din symbol 0x100 -> 2 clocks later de=1, dout=0x00. Symbol 0x2FF -> dout=0xFE. Token 1010101011 -> de=0, c1=1, c0=1.
4. Locked, then data-only (0x100) for 2100 cycles -> locked falls at timer 2047, state=SEARCH, bit_offset unchanged, outputs forced to 0.
5. 63 tokens then one data symbol, repeated -> never leaves SEARCH; bit_offset keeps slipping with wrap 9->0.
6. reset_n pulsed low mid-data while locked -> all outputs 0 asynchronously; after release, relocks per scenario 1.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive lane: control tokens, alignment
// states and the token-to-control-bit lookup.
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } tmds_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;     // {c1, c0}
    } token_info_t;

    function automatic token_info_t token_lookup(input logic [9:0] q);
        token_info_t r;
        r.is_ctrl = 1'b1;
        r.ctrl    = 2'b00;
        case (q)
            TOKEN_00: r.ctrl = 2'b00;
            TOKEN_01: r.ctrl = 2'b01;
            TOKEN_10: r.ctrl = 2'b10;
            TOKEN_11: r.ctrl = 2'b11;
            default:  r.is_ctrl = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b -> 8b TMDS symbol decode; also flags control tokens.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic       is_ctrl,
    output logic       c1,
    output logic       c0,
    output logic [7:0] d
);

    token_info_t tok;
    logic [7:0]  t;

    always_comb begin
        tok     = token_lookup(q);
        is_ctrl = tok.is_ctrl;
        c1      = tok.ctrl[1];
        c0      = tok.ctrl[0];
        // q[9] marks an inverted payload, q[8] selects XOR vs XNOR chaining
        t       = q[9] ? ~q[7:0] : q[7:0];
        d       = '0;
        d[0]    = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane: bit-slip word alignment on control-token runs, then a
// two-stage pipeline decoding symbols to pixel byte, C0/C1 and DE.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 64,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 2048,
    parameter int CNT_W          = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  din,
    output logic [7:0]  dout,
    output logic        c0,
    output logic        c1,
    output logic        de,
    output logic        locked,
    output logic [3:0]  bit_offset,
    output tmds_state_t state
);

    localparam logic [CNT_W-1:0] RUN_MAX     = CNT_W'(CTRL_RUN);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(CTRL_RUN - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

    logic [9:0]       din_prev;
    logic [18:0]      win;
    logic [9:0]       sym;
    logic [9:0]       sym_q;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] timer;
    tmds_state_t      state_nxt;
    logic             qual;
    logic             slip;
    logic             timer_clr;
    logic             s1_ctrl;
    logic             s1_c1;
    logic             s1_c0;
    logic [7:0]       s1_d;

    // Offset 9 reaches win[18]; din[9] only ever matters one cycle later via din_prev.
    assign win = {din[8:0], din_prev};

    always_comb begin
        sym = win[9:0];
        for (int i = 0; i < 10; i++) begin
            if (bit_offset == 4'(i)) sym = win[i +: 10];
        end
    end

    tmds_symbol_decode u_decode (
        .q       (sym_q),
        .is_ctrl (s1_ctrl),
        .c1      (s1_c1),
        .c0      (s1_c0),
        .d       (s1_d)
    );

    assign qual   = s1_ctrl && (run_cnt == RUN_LAST);
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else          state <= state_nxt;
    end

    // A qualifying run always beats a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        slip      = 1'b0;
        timer_clr = qual;
        case (state)
            SEARCH: begin
                if (qual)                      state_nxt = VERIFY;
                else if (timer == SEARCH_LAST) slip = 1'b1;
            end
            VERIFY: begin
                if (qual) begin
                    state_nxt = LOCKED;
                end else if (timer == LOCK_LAST) begin
                    slip      = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            LOCKED: begin
                if (!qual && timer == LOCK_LAST) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
        if (slip || state_nxt != state) timer_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_prev   <= '0;
            sym_q      <= '0;
            timer      <= '0;
            run_cnt    <= '0;
            bit_offset <= '0;
        end else begin
            din_prev <= din;
            sym_q    <= sym;
            timer    <= timer_clr ? '0 : timer + 1'b1;
            // Clearing on the slip keeps the stale pre-slip symbol out of the run.
            if (slip) begin
                bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
                run_cnt    <= '0;
            end else if (!s1_ctrl) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
            de   <= 1'b0;
            c1   <= 1'b0;
            c0   <= 1'b0;
        end else if (!locked) begin
            dout <= '0;
            de   <= 1'b0;
            c1   <= 1'b0;
            c0   <= 1'b0;
        end else if (s1_ctrl) begin
            dout <= '0;
            de   <= 1'b0;
            c1   <= s1_c1;
            c0   <= s1_c0;
        end else begin
            dout <= s1_d;
            de   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: expectations are stamped with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    localparam int EXP_W = 48;   // {stamp[31:0], kind[3:0], value[11:0]}
    localparam logic [3:0] K_LOCK  = 4'd0;
    localparam logic [3:0] K_OFF   = 4'd1;
    localparam logic [3:0] K_DE    = 4'd2;
    localparam logic [3:0] K_DOUT  = 4'd3;
    localparam logic [3:0] K_CTRL  = 4'd4;
    localparam logic [3:0] K_STATE = 4'd5;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  din     = '0;
    logic [7:0]  dout;
    logic        c0;
    logic        c1;
    logic        de;
    logic        locked;
    logic [3:0]  bit_offset;
    tmds_state_t state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [9:0] prev_sym = '0;
    int rot    = 0;
    int sent_c = 0;
    int q_edge = 0;

    logic [9:0] data_tab [6] = '{10'h100, 10'h2FF, 10'h1FF, 10'h0FF, 10'h10F, 10'h00F};
    logic [7:0] data_exp [6] = '{8'h00,   8'hFE,   8'h01,   8'hFF,   8'h11,   8'hEF};

    tmds_channel_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .dout       (dout),
        .c0         (c0),
        .c1         (c1),
        .de         (de),
        .locked     (locked),
        .bit_offset (bit_offset),
        .state      (state)
    );

    // ---------------- clock / reset / cycle stamp ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    function automatic string kname(input logic [3:0] kind);
        case (kind)
            K_LOCK:  return "locked";
            K_OFF:   return "bit_offset";
            K_DE:    return "de";
            K_DOUT:  return "dout";
            K_CTRL:  return "c1c0";
            K_STATE: return "state";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [11:0] actual(input logic [3:0] kind);
        case (kind)
            K_LOCK:  return {11'd0, locked};
            K_OFF:   return {8'd0, bit_offset};
            K_DE:    return {11'd0, de};
            K_DOUT:  return {4'd0, dout};
            K_CTRL:  return {10'd0, c1, c0};
            K_STATE: return {10'd0, 2'(state)};
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int stamp, input logic [3:0] kind, input logic [11:0] val);
        exp_q.push_back({32'(stamp), kind, val});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                logic [EXP_W-1:0] e;
                e = exp_q[i];
                if (int'(e[47:16]) == cyc) begin
                    check(kname(e[15:12]), actual(e[15:12]), e[11:0]);
                    exp_q.delete(i);
                end else if (int'(e[47:16]) < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missed_%s: stamp %0d passed at cyc %0d", kname(e[15:12]),
                             int'(e[47:16]), cyc);
                    exp_q.delete(i);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // rot models a serial stream delayed by rot bits ahead of the deserializer.
    task automatic send(input logic [9:0] s);
        logic [19:0] pair;
        @(posedge clk);
        #1;
        pair     = {s, prev_sym} >> (10 - rot);
        din      = pair[9:0];
        prev_sym = s;
        sent_c   = cyc;
    endtask

    task automatic video_line(input int n_tok, input int n_data, input bit chk);
        for (int i = 1; i <= n_tok; i++) begin
            send(TOKEN_00);
            if (i == 64) q_edge = sent_c + 3;
            if (chk && i == 100) begin
                expect_at(sent_c + 3, K_DE, 12'd0);
                expect_at(sent_c + 3, K_CTRL, 12'd0);
                expect_at(sent_c + 3, K_DOUT, 12'd0);
            end
        end
        for (int j = 0; j < n_data; j++) begin
            send(data_tab[j % 6]);
            if (chk && j < 6) begin
                expect_at(sent_c + 3, K_DE, 12'd1);
                expect_at(sent_c + 3, K_DOUT, {4'd0, data_exp[j % 6]});
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations still pending at cyc %0d", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_dout",   {4'd0, dout}, 12'd0);
        check("rst_de",     {11'd0, de}, 12'd0);
        check("rst_c1c0",   {10'd0, c1, c0}, 12'd0);
        check("rst_locked", {11'd0, locked}, 12'd0);
        check("rst_offset", {8'd0, bit_offset}, 12'd0);
        check("rst_state",  {10'd0, 2'(state)}, 12'(SEARCH));
        din      = '0;
        prev_sym = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic expect_aligned_lock();
        expect_at(66,  K_STATE, 12'(SEARCH));
        expect_at(67,  K_STATE, 12'(VERIFY));
        expect_at(866, K_LOCK, 12'd0);
        expect_at(867, K_LOCK, 12'd1);
        expect_at(867, K_OFF, 12'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // aligned stream: lock on second blanking, then decode checks and lock loss
        rot = 0;
        pulse_reset();
        expect_aligned_lock();
        expect_at(165, K_DE, 12'd0);
        expect_at(165, K_DOUT, 12'd0);
        video_line(160, 640, 1'b0);
        video_line(160, 640, 1'b1);
        video_line(160, 0, 1'b1);
        send(10'h100);
        expect_at(sent_c + 3, K_DE, 12'd1);
        expect_at(sent_c + 3, K_DOUT, 12'h00);
        send(10'h2FF);
        expect_at(sent_c + 3, K_DOUT, 12'hFE);
        send(TOKEN_11);
        expect_at(sent_c + 3, K_DE, 12'd0);
        expect_at(sent_c + 3, K_CTRL, 12'd3);
        expect_at(sent_c + 3, K_DOUT, 12'd0);
        send(10'h100);
        expect_at(sent_c + 3, K_DE, 12'd1);
        expect_at(sent_c + 3, K_CTRL, 12'd3);
        expect_at(q_edge + 2047, K_LOCK, 12'd1);
        expect_at(q_edge + 2048, K_LOCK, 12'd0);
        expect_at(q_edge + 2048, K_STATE, 12'(SEARCH));
        expect_at(q_edge + 2048, K_OFF, 12'd0);
        expect_at(q_edge + 2050, K_DE, 12'd0);
        expect_at(q_edge + 2050, K_CTRL, 12'd0);
        repeat (2100) send(10'h100);
        drain();

        // 63-token runs never qualify: offset slips every 2048 cycles and wraps
        pulse_reset();
        for (int k = 1; k <= 10; k++) begin
            expect_at(2048 * k - 1, K_OFF, 12'((k - 1) % 10));
            expect_at(2048 * k, K_OFF, 12'(k % 10));
            expect_at(2048 * k, K_STATE, 12'(SEARCH));
        end
        expect_at(10000, K_LOCK, 12'd0);
        for (int g = 0; g < 322; g++) begin
            repeat (63) send(TOKEN_00);
            send(10'h100);
        end
        drain();

        // stream delayed by 3 bits: three slips, then lock at offset 3
        rot = 3;
        pulse_reset();
        expect_at(2047, K_OFF, 12'd0);
        expect_at(2048, K_OFF, 12'd1);
        expect_at(4000, K_LOCK, 12'd0);
        expect_at(4095, K_OFF, 12'd1);
        expect_at(4096, K_OFF, 12'd2);
        expect_at(6143, K_OFF, 12'd2);
        expect_at(6144, K_OFF, 12'd3);
        expect_at(6466, K_STATE, 12'(SEARCH));
        expect_at(6467, K_STATE, 12'(VERIFY));
        expect_at(7266, K_LOCK, 12'd0);
        expect_at(7267, K_LOCK, 12'd1);
        expect_at(7267, K_OFF, 12'd3);
        for (int n = 1; n <= 9; n++) video_line(160, 640, 1'b0);
        video_line(160, 640, 1'b1);
        video_line(160, 20, 1'b0);
        drain();

        // asynchronous reset mid-data while locked, then relock on an aligned stream
        pulse_reset();
        rot = 0;
        expect_aligned_lock();
        video_line(160, 640, 1'b0);
        video_line(160, 640, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
